// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in and instruction-memory write port out
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a checksummed byte-stream image into imem, then releases the core
module imem_boot_loader #(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   words_loaded_o
);
    typedef enum logic [2:0] {S_HDR, S_LOAD, S_CSUM, S_DONE, S_ERROR} state_t;

    localparam logic [31:0]     DEPTH_W = 32'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [31:0]       acc_q, acc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              accept;
    logic [31:0]       word;
    logic [ADDR_W:0]   idx_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR;
            cnt_q   <= '0;
            shift_q <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        n_d     = n_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        accept  = bus.in_valid && ready_q;
        // The fourth byte completes the word straight from the bus; earlier bytes sit in shift_q.
        word    = {bus.in_data, shift_q};
        idx_inc = idx_q + IDX_ONE;

        if (accept) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {bus.in_data, shift_q[23:8]};
            if (cnt_q == 2'd3) begin
                case (state_q)
                    S_HDR: begin
                        idx_d = '0;
                        acc_d = '0;
                        if (word > DEPTH_W) begin
                            state_d = S_ERROR;
                        end else begin
                            n_d     = word[ADDR_W:0];
                            state_d = (word == 32'd0) ? S_CSUM : S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = word;
                        idx_d   = idx_inc;
                        acc_d   = acc_q + word;
                        if (idx_inc == n_q) state_d = S_CSUM;
                    end
                    S_CSUM:  state_d = (word == acc_q) ? S_DONE : S_ERROR;
                    default: state_d = state_q;
                endcase
            end
        end

        // Flags are registered from the next state so they move on the deciding edge.
        ready_d = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CSUM);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERROR);
    end

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign core_rst_o     = done_q;
    assign words_loaded_o = idx_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized image loads checked against a byte-stream reference model
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_rst, done, error;
    logic [10:0] words_loaded;
    int          total = 0;
    int          bad   = 0;

    imem_boot_loader_if #(.ADDR_W(10)) bus ();

    imem_boot_loader #(.IMEM_DEPTH(1024), .ADDR_W(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .core_rst_o     (core_rst),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    // Reference model state: every byte the loader has taken since reset.
    logic [7:0]  q[$];
    bit          m_up, m_acc_last;
    bit          e_ready, e_done, e_err, e_we;
    longint      e_wl, e_addr, e_data;
    logic [9:0]  wlog_addr[$];
    logic [31:0] wlog_data[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int k);
        return {q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]};
    endfunction

    // Derive every expected output purely from the accepted byte history.
    function automatic void eval();
        longint      len = longint'(q.size());
        longint      n, p;
        logic [31:0] s;
        e_done = 0; e_err = 0; e_we = 0; e_wl = 0; e_addr = 0; e_data = 0;
        if (len >= 4) begin
            n = longint'(word_at(0));
            if (n > 1024) begin
                e_err = 1;
            end else begin
                p    = (len - 4) / 4;
                e_wl = (p > n) ? n : p;
                if (len >= 4 * n + 8) begin
                    s = 32'd0;
                    for (int k = 1; k <= int'(n); k++) s = s + word_at(k);
                    if (word_at(int'(n) + 1) == s) e_done = 1;
                    else                           e_err  = 1;
                end
                if (m_acc_last && (len % 4 == 0) && p >= 1 && p <= n) begin
                    e_we   = 1;
                    e_addr = p - 1;
                    e_data = longint'(word_at(int'(p)));
                end
            end
        end
        e_ready = m_up && !e_done && !e_err;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_up       = 0;
            m_acc_last = 0;
        end else begin
            eval();
            m_acc_last = m_up && e_ready && (bus.in_valid === 1'b1);
            if (m_acc_last) q.push_back(bus.in_data);
            m_up = 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            eval();
            check("in_ready", longint'(bus.in_ready), longint'(e_ready));
            check("imem_we", longint'(bus.imem_we), longint'(e_we));
            check("done", longint'(done), longint'(e_done));
            check("error", longint'(error), longint'(e_err));
            check("core_rst", longint'(core_rst), longint'(e_done));
            check("words_loaded", longint'(words_loaded), e_wl);
            if (e_we) begin
                check("imem_addr", longint'(bus.imem_addr), e_addr);
                check("imem_wdata", longint'(bus.imem_wdata), e_data);
            end
            if (bus.imem_we === 1'b1) begin
                wlog_addr.push_back(bus.imem_addr);
                wlog_data.push_back(bus.imem_wdata);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
        int idle;
        bit got;
        idle = int'($urandom_range(hi, lo));
        repeat (idle) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            if (t > 0) @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: byte %02h not taken within 20 cycles", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int lo, input int hi);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], lo, hi);
    endtask

    task automatic settle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    task automatic scenario1(input logic [31:0] csum, input int lo, input int hi);
        send_word(32'd3, lo, hi);
        send_word(32'h0000_0013, lo, hi);
        send_word(32'h0050_0093, lo, hi);
        send_word(32'h00A0_0113, lo, hi);
        send_word(csum, lo, hi);
        settle();
    endtask

    task automatic check_s1_writes(input string tag);
        check({tag, "_nwrites"}, longint'(wlog_addr.size()), 3);
        if (wlog_addr.size() == 3) begin
            check({tag, "_a2"}, longint'(wlog_addr[2]), 2);
            check({tag, "_d0"}, longint'(wlog_data[0]), 64'h13);
            check({tag, "_d2"}, longint'(wlog_data[2]), 64'hA00113);
        end
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [31:0] sum;
        int          n;
        bit          good;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 0);
        check("rst_we", longint'(bus.imem_we), 0);
        check("rst_flags", longint'({done, error, core_rst}), 0);
        check("rst_words", longint'(words_loaded), 0);
        #2 rst = 1'b1;

        scenario1(32'h00F0_01B9, 0, 0);
        check("s1_done", longint'({done, error, core_rst, bus.in_ready}), 64'b1010);
        check("s1_words", longint'(words_loaded), 3);
        check_s1_writes("s1");

        pulse_reset();
        scenario1(32'h00F0_01B8, 0, 0);
        check("s2_flags", longint'({done, error, core_rst, bus.in_ready}), 64'b0100);
        check_s1_writes("s2");

        pulse_reset();
        send_word(32'd0, 0, 1);
        send_word(32'd0, 0, 1);
        settle();
        check("s3_done", longint'({done, error}), 64'b10);
        check("s3_nwrites", longint'(wlog_addr.size()), 0);

        pulse_reset();
        send_word(32'd1025, 0, 0);
        @(negedge clk);
        check("s4_err_next", longint'(error), 1);
        bus.in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            bus.in_data = 8'($urandom);
        end
        settle();
        check("s4_nwrites", longint'(wlog_addr.size()), 0);
        check("s4_ready", longint'(bus.in_ready), 0);

        pulse_reset();
        scenario1(32'h00F0_01B9, 1, 3);
        check("s5_flags", longint'({done, error, core_rst}), 64'b101);
        check_s1_writes("s5");

        pulse_reset();
        send_word(32'd3, 0, 1);
        send_word(32'h0000_0013, 0, 1);
        send_byte(8'h93, 0, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("s6_async_zero",
              longint'({bus.in_ready, bus.imem_we, done, error, core_rst, words_loaded}), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        wlog_addr.delete();
        wlog_data.delete();
        send_word(32'd1, 0, 1);
        send_word(32'hDEAD_BEEF, 0, 1);
        send_word(32'hDEAD_BEEF, 0, 1);
        settle();
        check("s6_done", longint'({done, error}), 64'b10);
        check("s6_nwrites", longint'(wlog_addr.size()), 1);
        if (wlog_addr.size() == 1) begin
            check("s6_addr", longint'(wlog_addr[0]), 0);
            check("s6_data", longint'(wlog_data[0]), 64'hDEADBEEF);
        end

        for (int img = 0; img < 6; img++) begin
            pulse_reset();
            n    = int'($urandom_range(6, 1));
            good = ($urandom_range(1, 0) == 1);
            ws.delete();
            sum = 32'd0;
            for (int k = 0; k < n; k++) begin
                ws.push_back($urandom);
                sum = sum + ws[k];
            end
            send_word(32'(n), 0, 2);
            foreach (ws[k]) send_word(ws[k], 0, 2);
            send_word(good ? sum : (sum ^ (32'd1 << $urandom_range(31, 0))), 0, 2);
            settle();
            check("rand_flags", longint'({done, error}), good ? 64'b10 : 64'b01);
            check("rand_nwrites", longint'(wlog_addr.size()), longint'(n));
        end

        pulse_reset();
        send_word(32'd1024, 0, 0);
        for (int k = 0; k < 1024; k++) send_word(32'(k * 3 + 1), 0, 0);
        // sum of 3k+1 over k=0..1023 = 3*523776 + 1024 = 1572352
        send_word(32'd1572352, 0, 0);
        settle();
        check("full_done", longint'({done, error}), 64'b10);
        check("full_words", longint'(words_loaded), 1024);
        check("full_nwrites", longint'(wlog_addr.size()), 1024);
        if (wlog_addr.size() == 1024) check("full_last_addr", longint'(wlog_addr[1023]), 1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end
endmodule
